// File: rtl/paralelo_serial_ctrl.sv
// Frame sequencer for an external parallel/serial shift register: start, data LSB-first, [parity], stop.
// Optional even-parity bit is compiled in when PARALELO_SERIAL_PARITY_EN is defined.
module paralelo_serial_ctrl #(
  parameter int NBITS_DATA   = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NBITS_DATA-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  reg_sel,
  output logic [NBITS_DATA-1:0] reg_din,
  output logic                  reg_din_serie,
  input  logic [NBITS_DATA-1:0] reg_dout,
  output logic                  ser_out,
  output logic                  busy,
  output logic                  done
);

  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(NBITS_DATA + 1);
  localparam logic [PW-1:0] PER_LAST = PW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS_DATA - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef PARALELO_SERIAL_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [PW-1:0] r_per_cnt;
  logic [BW-1:0] r_bit_cnt;
  logic          r_done;
  logic          w_per_last;
  logic          w_accept;

  assign w_per_last    = (r_per_cnt == PER_LAST);
  assign w_accept      = (r_state == IDLE) && s_valid;
  assign reg_din_serie = 1'b0;
  assign done          = r_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_per_cnt <= '0;
      r_bit_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == STOP) && w_per_last;
      if (w_accept) begin
        r_per_cnt <= '0;
        r_bit_cnt <= '0;
      end else if (r_state != IDLE) begin
        r_per_cnt <= w_per_last ? '0 : r_per_cnt + PW'(1);
        if ((r_state == DATA) && w_per_last) begin
          r_bit_cnt <= r_bit_cnt + BW'(1);
        end
      end
    end
  end

`ifdef PARALELO_SERIAL_PARITY_EN
  logic r_parity;

  // Parity is taken from s_data at the handshake, before the register shifts it away.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^s_data;
    end
  end
`endif

  always_comb begin
    w_next  = r_state;
    s_ready = 1'b0;
    busy    = 1'b1;
    ser_out = 1'b1;
    reg_sel = 1'b0;
    reg_din = reg_dout;
    case (r_state)
      IDLE: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        reg_din = s_data;
        if (s_valid) w_next = START;
      end
      START: begin
        ser_out = 1'b0;
        if (w_per_last) w_next = DATA;
      end
      DATA: begin
        ser_out = reg_dout[0];
        if (w_per_last) begin
          reg_sel = 1'b1;
          if (r_bit_cnt == BIT_LAST) begin
`ifdef PARALELO_SERIAL_PARITY_EN
            w_next = PARITY;
`else
            w_next = STOP;
`endif
          end
        end
      end
`ifdef PARALELO_SERIAL_PARITY_EN
      PARITY: begin
        ser_out = r_parity;
        if (w_per_last) w_next = STOP;
      end
`endif
      STOP: begin
        if (w_per_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: doc/paralelo_serial_ctrl.md
# paralelo_serial_ctrl

Frame sequencer for the parallel/serial shift register (`NBITS_DATA`-bit, `SEL`=0 parallel load, `SEL`=1 shift right with serial-in at MSB). It accepts a data word through a valid/ready handshake and loads it into the register. It then emits a UART-style frame on `ser_out`: start bit, data LSB-first, optional parity, stop bit, with each bit held for `CLKS_PER_BIT` clocks. The controller does not contain the register. It drives the register's `SEL`/`Din`/`Din_serie` and observes its `Dout`.

## Interface
- `NBITS_DATA`, 4, data word width; must match the controlled register.
- `CLKS_PER_BIT`, 4, clocks per serial bit; ≥1.
- `clk` input 1: rising-edge clock, shared with the register.
- `reset` input 1: asynchronous, active-low reset.
- `s_data` input `NBITS_DATA`: word to transmit.
- `s_valid` input 1: `s_data` valid.
- `s_ready` output 1: controller can accept a word.
- `reg_sel` output 1: drives register `SEL`.
- `reg_din` output `NBITS_DATA`: drives register `Din`.
- `reg_din_serie` output 1: drives register `Din_serie`; constant 0.
- `reg_dout` input `NBITS_DATA`: register `Dout`.
- `ser_out` output 1: serial line; idle high.
- `busy` output 1: frame in progress.
- `done` output 1: one-cycle pulse when a frame completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP. Counters:
  - `per_cnt`: 0..`CLKS_PER_BIT`-1, width `max(1,$clog2(CLKS_PER_BIT))`.
  - `bit_cnt`: 0..`NBITS_DATA`, width `$clog2(NBITS_DATA+1)`.
- IDLE:
  - Outputs: `s_ready`=1, `busy`=0, `ser_out`=1.
  - Register drive: `reg_sel`=0 and `reg_din`=`s_data`, so the register tracks `s_data` every cycle.
  - On the edge with `s_valid && s_ready`: the register captures the word and the FSM goes to START.
  - On that same edge: `per_cnt`←0, `bit_cnt`←0, and the parity flop ← `^s_data`.
- Hold rule: in START, PARITY, STOP, and DATA when `per_cnt`≠`CLKS_PER_BIT`-1, drive `reg_sel`=0 and `reg_din`=`reg_dout`. The register keeps its value.
- START: `ser_out`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA:
  - `ser_out`=`reg_dout[0]`.
  - On the last cycle of each bit period: `reg_sel`=1 (register shifts right, 0 enters the MSB) and `bit_cnt`++.
  - After `NBITS_DATA` bits: go to PARITY if compiled in, else STOP. The register then holds all zeros.
- PARITY: `ser_out`=parity flop for `CLKS_PER_BIT` cycles, then go to STOP.
- STOP: `ser_out`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- `per_cnt` wraps to 0 at the end of every bit period.
- `busy`=1 and `s_ready`=0 in every state except IDLE. `s_valid` outside IDLE is ignored and never lost: the word stays pending until `s_ready`.
- `done` is a registered pulse, high for exactly the first IDLE cycle after STOP.
- Back-to-back frames: a handshake on the same cycle `done`=1 starts the next frame with no gap cycle.
- `CLKS_PER_BIT`=1: no hold cycles, and DATA shifts every clock.
- Reset (asynchronous, any state):
  - State and counters: state=IDLE, counters=0, parity flop=0, `done`=0.
  - Outputs while `reset` is low: `ser_out`=1, `busy`=0, `s_ready`=1, `reg_sel`=0.
  - Reset mid-frame aborts the frame with no `done`.

## Timing
- Handshake edge E0. START occupies cycles 1..`CLKS_PER_BIT` after E0.
- Data bit k (k from 0) appears on `ser_out` from cycle (1+k)·`CLKS_PER_BIT`+1 after E0.
- Frame length F = (2+`NBITS_DATA`+P)·`CLKS_PER_BIT` cycles, where P=1 with parity, else 0.
  - `done` is high in cycle F+1 after E0.
  - `s_ready` rises in that same cycle.
- All outputs except `done` are combinational from state/counters/`s_data`/`reg_dout`; `done` is a flop.
- Zero-latency load: the register holds the word the cycle after E0.

## Configuration
- `PARALELO_SERIAL_PARITY_EN` defined:
  - PARITY state is present.
  - Even parity bit = XOR of the word, sent after the data bits.
  - F includes P=1.
- Macro undefined:
  - PARITY state and the parity flop are removed.
  - DATA goes directly to STOP, and P=0.

## Test plan
- Reset, then idle with `s_valid`=0 → `ser_out`=1, `s_ready`=1, `busy`=0; register tracks `s_data`.
- `NBITS_DATA`=4, `CLKS_PER_BIT`=4, macro off, send 4'b1011 → `ser_out`=0,1,1,0,1,1, each held 4 cycles; `done` pulses at cycle 25 after E0.
- Same word, macro on → `ser_out`=0,1,1,0,1,1(parity),1; `done` at cycle 29 after E0.
- Send 4'hA with `s_valid` held high and the next word 4'h5 queued → 4'h5 is accepted on the `done` cycle; the second start bit begins the next cycle with no idle gap; `s_ready` is 0 throughout each frame.
- `CLKS_PER_BIT`=1, send 4'b0110 → `reg_sel`=1 on 4 consecutive cycles, `ser_out`=0,0,1,1,0,1; F=6.
- Assert `reset` low during DATA bit 2 → immediately IDLE, `ser_out`=1, `busy`=0, no `done`; the next handshake sends a full, correct frame.
